// File: rtl/piso_reader_pkg.sv
// ---------------------------------------------------------------------------
// piso_reader_pkg
// Shared definitions for the 74LV165 shift-register reader:
//   - state_t       : scan sequencer states
//   - DEF_*         : default clocking constants for a 20 MHz logic clock
//   - cycles_for_hz : helper turning a target rate into aclk cycles
// Optional feature macro used by piso_reader: PISO_READER_DEBOUNCE_EN
// ---------------------------------------------------------------------------
package piso_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_CMP      = 3'd5
    } state_t;

    // Number of aclk cycles in one period of a signal running at rate_hz.
    function automatic int unsigned cycles_for_hz(input int unsigned clk_hz,
                                                  input int unsigned rate_hz);
        return clk_hz / rate_hz;
    endfunction

    localparam int unsigned DEF_ACLK_HZ       = 20_000_000;
    localparam int unsigned DEF_NUMBER_INPUTS = 8;
    // Half of a 100 kHz shift clock period.
    localparam int unsigned DEF_CLK_HALF      = cycles_for_hz(DEF_ACLK_HZ, 100_000) / 2;
    // One scan every 1 ms.
    localparam int unsigned DEF_SCAN_PERIOD   = cycles_for_hz(DEF_ACLK_HZ, 1_000);

endpackage

// File: rtl/piso_reader_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing one asynchronous bit into the aclk domain.
// Ports:
//   aclk   - destination clock
//   areset - asynchronous active-high reset (flops clear to 0)
//   reset  - synchronous active-high reset (flops clear to 0)
//   d      - asynchronous input bit
//   q      - synchronized output bit (two aclk cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic aclk,
    input  logic areset,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        if (reset) begin
            meta_d = 1'b0;
            sync_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/piso_reader.sv
// ---------------------------------------------------------------------------
// piso_reader
// Periodically scans a 74LV165 parallel-in/serial-out shift register and
// reports the input word whenever it changes (and always on the first
// completed scan after reset).
// Parameters:
//   P_NUMBER_INPUTS - parallel inputs read per scan
//   P_CLK_HALF      - aclk cycles per half-period of the shift clock
//   P_SCAN_PERIOD   - aclk cycles between scan starts
// Ports:
//   aclk                    - 20 MHz logic clock
//   areset                  - asynchronous active-high reset
//   reset                   - synchronous active-high reset
//   en                      - asynchronous run-enable (synchronized inside)
//   SGPIO_FPGA_DBG_LD_N     - SH/LD_N pin, parallel load while low
//   SGPIO_FPGA_DBG_CLK_100k - CP shift clock pin
//   SGPIO_FPGA_DBG_DATA_IN  - Q7 serial data, asynchronous
//   o_data                  - last reported input word (held between pulses)
//   o_valid                 - one-cycle pulse qualifying a new o_data
//   o_busy                  - high whenever the sequencer is not idle
// Optional feature: define PISO_READER_DEBOUNCE_EN to require two identical
// consecutive scans before a changed word is reported.
// ---------------------------------------------------------------------------
module piso_reader
    import piso_reader_pkg::*;
#(
    parameter int P_NUMBER_INPUTS = DEF_NUMBER_INPUTS,
    parameter int P_CLK_HALF      = DEF_CLK_HALF,
    parameter int P_SCAN_PERIOD   = DEF_SCAN_PERIOD
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       reset,
    input  logic                       en,
    output logic                       SGPIO_FPGA_DBG_LD_N,
    output logic                       SGPIO_FPGA_DBG_CLK_100k,
    input  logic                       SGPIO_FPGA_DBG_DATA_IN,
    output logic [P_NUMBER_INPUTS-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_busy
);

    localparam int TW = $clog2(P_SCAN_PERIOD + 1);
    localparam int HW = $clog2(P_CLK_HALF + 1);
    localparam int BW = $clog2(P_NUMBER_INPUTS + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(P_SCAN_PERIOD - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(P_CLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(P_NUMBER_INPUTS - 1);

    logic en_s;
    logic data_s;

    sync_2ff u_sync_en (
        .aclk   (aclk),
        .areset (areset),
        .reset  (reset),
        .d      (en),
        .q      (en_s)
    );

    sync_2ff u_sync_data (
        .aclk   (aclk),
        .areset (areset),
        .reset  (reset),
        .d      (SGPIO_FPGA_DBG_DATA_IN),
        .q      (data_s)
    );

    state_t                     state_q,  state_d;
    logic [TW-1:0]              timer_q,  timer_d;
    logic [HW-1:0]              half_q,   half_d;
    logic [BW-1:0]              bit_q,    bit_d;
    logic [P_NUMBER_INPUTS-1:0] shift_q,  shift_d;
    logic [P_NUMBER_INPUTS-1:0] data_q,   data_d;
    logic                       valid_q,  valid_d;
    logic                       first_q,  first_d;
    logic                       ld_n_q,   ld_n_d;
    logic                       clk_q,    clk_d;
`ifdef PISO_READER_DEBOUNCE_EN
    logic [P_NUMBER_INPUTS-1:0] cand_q,     cand_d;
    logic                       cand_vld_q, cand_vld_d;
`endif

    logic half_last;
    logic timer_wrap;
    logic word_changed;

    assign half_last    = (half_q == HALF_LAST);
    assign timer_wrap   = (timer_q == TIMER_LAST);
    assign word_changed = first_q || (shift_q != data_q);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        half_d  = half_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        first_d = first_q;
`ifdef PISO_READER_DEBOUNCE_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
`endif

        // The scan timer keeps its phase across scans so starts stay evenly
        // spaced; it is parked at zero while the reader is disabled.
        if (!en_s || timer_wrap) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_s && timer_wrap) begin
                    state_d = ST_LOAD;
                    half_d  = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end

            ST_LOAD: begin
                if (half_last) begin
                    state_d = ST_SETUP;
                    half_d  = '0;
                end else begin
                    half_d  = half_q + 1'b1;
                end
            end

            ST_SETUP: begin
                if (half_last) begin
                    state_d = ST_SHIFT_LO;
                    half_d  = '0;
                end else begin
                    half_d  = half_q + 1'b1;
                end
            end

            // Q7 is stable for the whole low phase; sampling at its end
            // leaves the synchronizer latency well inside the window.
            ST_SHIFT_LO: begin
                if (half_last) begin
                    shift_d = (shift_q << 1) | P_NUMBER_INPUTS'(data_s);
                    bit_d   = bit_q + 1'b1;
                    half_d  = '0;
                    state_d = (bit_q == BIT_LAST) ? ST_CMP : ST_SHIFT_HI;
                end else begin
                    half_d  = half_q + 1'b1;
                end
            end

            ST_SHIFT_HI: begin
                if (half_last) begin
                    state_d = ST_SHIFT_LO;
                    half_d  = '0;
                end else begin
                    half_d  = half_q + 1'b1;
                end
            end

            ST_CMP: begin
                state_d = ST_IDLE;
                half_d  = '0;
                bit_d   = '0;
`ifdef PISO_READER_DEBOUNCE_EN
                // The first scan after reset reports straight away; after
                // that a new word must be seen twice in a row.
                if (first_q) begin
                    data_d     = shift_q;
                    valid_d    = 1'b1;
                    first_d    = 1'b0;
                    cand_vld_d = 1'b0;
                end else if (!word_changed) begin
                    cand_vld_d = 1'b0;
                end else if (cand_vld_q && (cand_q == shift_q)) begin
                    data_d     = shift_q;
                    valid_d    = 1'b1;
                    cand_vld_d = 1'b0;
                end else begin
                    cand_d     = shift_q;
                    cand_vld_d = 1'b1;
                end
`else
                if (word_changed) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    first_d = 1'b0;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing enable mid-scan throws the partial word away, including a
        // pending report from the CMP cycle.
        if (!en_s && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            half_d  = '0;
            bit_d   = '0;
            shift_d = '0;
            data_d  = data_q;
            valid_d = 1'b0;
            first_d = first_q;
`ifdef PISO_READER_DEBOUNCE_EN
            cand_d     = cand_q;
            cand_vld_d = 1'b0;
`endif
        end

        if (reset) begin
            state_d = ST_IDLE;
            timer_d = '0;
            half_d  = '0;
            bit_d   = '0;
            shift_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
            first_d = 1'b1;
`ifdef PISO_READER_DEBOUNCE_EN
            cand_d     = '0;
            cand_vld_d = 1'b0;
`endif
        end

        // Pin levels are decoded from the next state so they change on the
        // same edge as the state register.
        ld_n_d = (state_d != ST_LOAD);
        clk_d  = (state_d == ST_SHIFT_HI);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            half_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b1;
            ld_n_q  <= 1'b1;
            clk_q   <= 1'b0;
`ifdef PISO_READER_DEBOUNCE_EN
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            ld_n_q  <= ld_n_d;
            clk_q   <= clk_d;
`ifdef PISO_READER_DEBOUNCE_EN
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
`endif
        end
    end

    assign SGPIO_FPGA_DBG_LD_N     = ld_n_q;
    assign SGPIO_FPGA_DBG_CLK_100k = clk_q;
    assign o_data                  = data_q;
    assign o_valid                 = valid_q;
    assign o_busy                  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_reader.sv
// ---------------------------------------------------------------------------
// tb_piso_reader
// Drives piso_reader against a behavioural 74LV165 model with directed input
// words and checks reporting, pin timing, abort and reset behaviour.
// Define PISO_READER_DEBOUNCE_EN for both files to exercise the debounce build.
// ---------------------------------------------------------------------------
module tb_piso_reader;

    localparam int N      = 8;
    localparam int HALF   = 100;
    localparam int PERIOD = 2000;
    localparam int BOUND  = 6000;

    logic         aclk   = 1'b0;
    logic         areset = 1'b0;
    logic         reset  = 1'b0;
    logic         en     = 1'b0;
    logic         ld_n;
    logic         cp;
    logic         q7;
    logic [N-1:0] o_data;
    logic         o_valid;
    logic         o_busy;

    logic [N-1:0] piso_in = 8'hA5;
    logic [N-1:0] piso_sr = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    int valid_total = 0;
    int vrun        = 0;
    int vrun_max    = 0;
    int hi_run      = 0;
    int clk_hi_last = 0;
    int lo_run      = 0;
    int ld_lo_last  = 0;
    int busy_rises  = 0;
    int cp_rises    = 0;
    logic cp_prev   = 1'b0;
    logic ld_prev   = 1'b1;
    logic busy_prev = 1'b0;

    // 20 MHz logic clock.
    always #25 aclk = ~aclk;

    piso_reader #(
        .P_NUMBER_INPUTS (N),
        .P_CLK_HALF      (HALF),
        .P_SCAN_PERIOD   (PERIOD)
    ) dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .reset                   (reset),
        .en                      (en),
        .SGPIO_FPGA_DBG_LD_N     (ld_n),
        .SGPIO_FPGA_DBG_CLK_100k (cp),
        .SGPIO_FPGA_DBG_DATA_IN  (q7),
        .o_data                  (o_data),
        .o_valid                 (o_valid),
        .o_busy                  (o_busy)
    );

    // 74LV165: asynchronous parallel load while SH/LD_N is low, shift toward
    // Q7 on each CP rising edge with SER tied low.
    always @(posedge cp or negedge ld_n) begin
        if (!ld_n) piso_sr <= piso_in;
        else       piso_sr <= {piso_sr[N-2:0], 1'b0};
    end
    assign q7 = piso_sr[N-1];

    // Pin and pulse monitor, sampled half a cycle away from the active edge.
    always @(negedge aclk) begin
        if (cp) hi_run++;
        if (!cp && cp_prev) begin
            clk_hi_last = hi_run;
            hi_run = 0;
        end
        if (cp && !cp_prev) cp_rises++;
        if (!ld_n) lo_run++;
        if (ld_n && !ld_prev) begin
            ld_lo_last = lo_run;
            lo_run = 0;
        end
        if (o_valid) begin
            valid_total++;
            vrun++;
            if (vrun > vrun_max) vrun_max = vrun;
        end else begin
            vrun = 0;
        end
        if (o_busy && !busy_prev) busy_rises++;
        cp_prev   = cp;
        ld_prev   = ld_n;
        busy_prev = o_busy;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] word, input logic enable);
        @(negedge aclk);
        piso_in = word;
        en      = enable;
    endtask

    task automatic waitBusyRise(input string tag);
        int i;
        i = 0;
        while (!o_busy && i < BOUND) begin
            @(negedge aclk);
            i++;
        end
        checkOutput(tag, {31'd0, o_busy}, 32'd1);
    endtask

    task automatic waitCpRises(input int n, input string tag);
        int start;
        int i;
        start = cp_rises;
        i = 0;
        while ((cp_rises - start) < n && i < BOUND) begin
            @(negedge aclk);
            i++;
        end
        checkOutput(tag, cp_rises - start, n);
    endtask

    // Runs one complete scan and returns the number of o_valid pulses seen.
    task automatic runScan(input string tag, output int vdelta);
        int start;
        int i;
        start = valid_total;
        waitBusyRise({tag, "_start"});
        i = 0;
        while (o_busy && i < BOUND) begin
            @(negedge aclk);
            i++;
        end
        checkOutput({tag, "_end"}, {31'd0, o_busy}, 32'd0);
        repeat (4) @(negedge aclk);
        vdelta = valid_total - start;
    endtask

    initial begin
        int vd;
        int vsum;
        int cp_start;
        int v_start;
        int b_start;

        #10 areset = 1'b1;
        repeat (3) @(negedge aclk);
        checkOutput("rst_ld_n",  {31'd0, ld_n},    32'd1);
        checkOutput("rst_clk",   {31'd0, cp},      32'd0);
        checkOutput("rst_data",  {24'd0, o_data},  32'd0);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_busy",  {31'd0, o_busy},  32'd0);
        areset = 1'b0;

        // First scan after reset always reports; seven CP pulses for 8 bits.
        applyStimulus(8'hA5, 1'b1);
        cp_start = cp_rises;
        runScan("scan1", vd);
        checkOutput("first_valid", vd, 1);
        checkOutput("first_data",  {24'd0, o_data}, 32'h0000_00A5);
        checkOutput("clk_hi_len",  clk_hi_last, HALF);
        checkOutput("ld_lo_len",   ld_lo_last, HALF);
        checkOutput("cp_pulses",   cp_rises - cp_start, N - 1);

        vsum = 0;
        for (int s = 0; s < 3; s++) begin
            runScan("hold", vd);
            vsum += vd;
        end
        checkOutput("hold_no_valid", vsum, 0);

        applyStimulus(8'h3C, 1'b1);
`ifdef PISO_READER_DEBOUNCE_EN
        runScan("chg_a", vd);
        checkOutput("chg_first_scan", vd, 0);
`endif
        runScan("chg", vd);
        checkOutput("chg_valid", vd, 1);
        checkOutput("chg_data",  {24'd0, o_data}, 32'h0000_003C);

`ifdef PISO_READER_DEBOUNCE_EN
        applyStimulus(8'hFF, 1'b1);
        runScan("glitch", vd);
        checkOutput("glitch_no_valid", vd, 0);
        applyStimulus(8'h3C, 1'b1);
        runScan("glitch_back", vd);
        checkOutput("glitch_back_no_valid", vd, 0);
        checkOutput("glitch_data", {24'd0, o_data}, 32'h0000_003C);
        applyStimulus(8'hFF, 1'b1);
        runScan("ff_a", vd);
        checkOutput("ff_a_no_valid", vd, 0);
        runScan("ff_b", vd);
        checkOutput("ff_b_valid", vd, 1);
        checkOutput("ff_b_data", {24'd0, o_data}, 32'h0000_00FF);
        applyStimulus(8'h3C, 1'b1);
        runScan("back_a", vd);
        runScan("back_b", vd);
        checkOutput("back_data", {24'd0, o_data}, 32'h0000_003C);
`endif

        // Drop enable while bit 4 is being shifted.
        applyStimulus(8'h81, 1'b1);
        v_start = valid_total;
        waitBusyRise("abort_start");
        waitCpRises(4, "abort_bit4");
        applyStimulus(8'h81, 1'b0);
        repeat (5) @(negedge aclk);
        checkOutput("abort_ld_n", {31'd0, ld_n},   32'd1);
        checkOutput("abort_clk",  {31'd0, cp},     32'd0);
        checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
        b_start = busy_rises;
        repeat (2500) @(negedge aclk);
        checkOutput("abort_no_valid", valid_total - v_start, 0);
        checkOutput("disabled_idle",  busy_rises - b_start, 0);
        checkOutput("abort_data",     {24'd0, o_data}, 32'h0000_003C);

        // Asynchronous reset in the middle of shifting.
        applyStimulus(8'h3C, 1'b1);
        waitBusyRise("arst_start");
        waitCpRises(3, "arst_bit3");
        #7 areset = 1'b1;
        @(negedge aclk);
        checkOutput("arst_ld_n",  {31'd0, ld_n},    32'd1);
        checkOutput("arst_clk",   {31'd0, cp},      32'd0);
        checkOutput("arst_data",  {24'd0, o_data},  32'd0);
        checkOutput("arst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("arst_busy",  {31'd0, o_busy},  32'd0);
        areset = 1'b0;
        runScan("arst_scan", vd);
        checkOutput("arst_report", vd, 1);
        checkOutput("arst_rdata",  {24'd0, o_data}, 32'h0000_003C);

        // Synchronous reset in the middle of shifting.
        waitBusyRise("srst_start");
        waitCpRises(2, "srst_bit2");
        reset = 1'b1;
        @(negedge aclk);
        checkOutput("srst_ld_n", {31'd0, ld_n},   32'd1);
        checkOutput("srst_clk",  {31'd0, cp},     32'd0);
        checkOutput("srst_data", {24'd0, o_data}, 32'd0);
        checkOutput("srst_busy", {31'd0, o_busy}, 32'd0);
        reset = 1'b0;
        runScan("srst_scan", vd);
        checkOutput("srst_report", vd, 1);
        checkOutput("srst_rdata",  {24'd0, o_data}, 32'h0000_003C);

        checkOutput("valid_width", vrun_max, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
